// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the output-layer neuron.
//   - datapath widths (N_IN, W_WIDTH, ACC_WIDTH) and the idx counter width
//   - register-file address map (ADDR_W0..ADDR_W3, ADDR_BIAS, ADDR_THR)
//   - FSM state enum
//   - sext() widens a weight to accumulator width; sat8() clamps the
//     accumulator into the 8-bit score range
package nn_pkg;

    localparam int N_IN      = 4;
    localparam int W_WIDTH   = 8;
    localparam int ACC_WIDTH = 11;
    localparam int IDX_WIDTH = $clog2(N_IN);

    localparam logic [2:0] ADDR_W0   = 3'd0;
    localparam logic [2:0] ADDR_W1   = 3'd1;
    localparam logic [2:0] ADDR_W2   = 3'd2;
    localparam logic [2:0] ADDR_W3   = 3'd3;
    localparam logic [2:0] ADDR_BIAS = 3'd4;
    localparam logic [2:0] ADDR_THR  = 3'd5;

    typedef logic signed [W_WIDTH-1:0]   w_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam w_t W_MAX = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam w_t W_MIN = {1'b1, {(W_WIDTH-1){1'b0}}};

    function automatic acc_t sext(input w_t w);
        return {{(ACC_WIDTH-W_WIDTH){w[W_WIDTH-1]}}, w};
    endfunction

    function automatic w_t sat8(input acc_t a);
        if (a > sext(W_MAX)) begin
            return W_MAX;
        end else if (a < sext(W_MIN)) begin
            return W_MIN;
        end else begin
            return a[W_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/output_layer_seq_if.sv
// output_layer_seq_if: handshake/bus bundle of the output neuron.
//   master (driver side): hidden, start, wr_en, wr_addr, wr_data
//   slave  (neuron side): y, score, valid, busy
interface output_layer_seq_if;
    import nn_pkg::*;

    logic [N_IN-1:0] hidden;   // activation bits, bit i = hidden neuron i
    logic            start;    // evaluation request, honoured only when idle
    logic            wr_en;    // register write strobe
    logic [2:0]      wr_addr;  // 0..3 weights, 4 bias, 5 threshold
    w_t              wr_data;  // signed write value

    logic            y;        // decision: acc > threshold
    w_t              score;    // saturated accumulator
    logic            valid;    // one-cycle pulse when y/score update
    logic            busy;     // evaluation in progress

    modport master (
        output hidden, start, wr_en, wr_addr, wr_data,
        input  y, score, valid, busy
    );

    modport slave (
        input  hidden, start, wr_en, wr_addr, wr_data,
        output y, score, valid, busy
    );

endinterface

// File: rtl/weight_regfile.sv
// weight_regfile: four weights, bias and threshold for the output neuron.
//   clk, rst_n : clock, async active-low reset (all registers clear to 0)
//   we         : write enable, already qualified by the caller
//   addr, data : write address / signed value; addresses 6..7 are ignored
//   weight, bias, thr : parallel read outputs, always reflecting the
//                       current register contents
module weight_regfile
    import nn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] addr,
    input  w_t         data,
    output w_t         weight [N_IN],
    output w_t         bias,
    output w_t         thr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small register array is reset explicitly because a
            // mid-operation reset must leave every weight at a known zero;
            // large storage arrays would normally be left unreset.
            for (int i = 0; i < N_IN; i++) begin
                weight[i] <= '0;
            end
            bias <= '0;
            thr  <= '0;
        end else if (we) begin
            // NOTE: non-blocking assignments here let every reader in the same
            // edge see the pre-write value, which is what gives the bias its
            // "old value on a simultaneous start" behaviour.
            case (addr)
                ADDR_W0:   weight[0] <= data;
                ADDR_W1:   weight[1] <= data;
                ADDR_W2:   weight[2] <= data;
                ADDR_W3:   weight[3] <= data;
                ADDR_BIAS: bias      <= data;
                ADDR_THR:  thr       <= data;
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/output_layer_seq.sv
// output_layer_seq: sequential output neuron. On start it latches the
// hidden activations, seeds the accumulator with the bias, adds one weight
// per cycle for four cycles, then registers the thresholded decision and
// the saturated score together with a one-cycle valid pulse.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of output_layer_seq_if (hidden/start/write port
//                in, y/score/valid/busy out)
module output_layer_seq
    import nn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    output_layer_seq_if.slave    bus
);

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(N_IN - 1);

    state_t               state_q, state_d;
    logic [N_IN-1:0]      h_q;
    logic [IDX_WIDTH-1:0] idx_q;
    acc_t                 acc_q;
    acc_t                 addend;
    logic                 y_q;
    w_t                   score_q;
    logic                 valid_q;

    w_t                   weight [N_IN];
    w_t                   bias;
    w_t                   thr;

    // Writes are accepted only while idle; anything issued during an
    // evaluation is dropped.
    weight_regfile u_regs (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.wr_en && (state_q == ST_IDLE)),
        .addr   (bus.wr_addr),
        .data   (bus.wr_data),
        .weight (weight),
        .bias   (bias),
        .thr    (thr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: next state defaults to the current one before the case so no
        // path through this block leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_ACCUM;
            ST_ACCUM: if (idx_q == IDX_LAST) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Single shared adder operand: the selected weight or zero.
    always_comb begin
        addend = '0;
        if (h_q[idx_q]) begin
            addend = sext(weight[idx_q]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            y_q     <= 1'b0;
            score_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        h_q   <= bus.hidden;
                        acc_q <= sext(bias);
                        idx_q <= '0;
                    end
                end
                ST_ACCUM: begin
                    acc_q <= acc_q + addend;
                    idx_q <= idx_q + 1'b1;
                end
                ST_DONE: begin
                    y_q     <= (acc_q > sext(thr));
                    score_q <= sat8(acc_q);
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.y     = y_q;
    assign bus.score = score_q;
    assign bus.valid = valid_q;
    assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_output_layer_seq.sv
// tb_output_layer_seq: directed bench for output_layer_seq. A behavioural
// model tracks the programmed registers and predicts each result as
// bias + sum of selected weights, delivered five edges after the start
// edge; a compare process checks valid/busy/y/score every cycle, and
// literal expectations pin the model on the documented vectors.
module tb_output_layer_seq;
    import nn_pkg::*;

    logic clk;
    logic rst_n;

    output_layer_seq_if bus ();

    output_layer_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_w [N_IN];
    int   m_bias, m_thr;
    int   m_cnt;        // 0 = idle, else edges elapsed since the start edge
    int   m_pend;       // result of the evaluation in flight
    logic m_y, m_valid;
    int   m_score;

    function automatic int clamp8(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    // Weight as seen during accumulation: a write on the start edge wins.
    function automatic int eff_w(input int i);
        if (bus.wr_en && (bus.wr_addr == 3'(i))) return int'(bus.wr_data);
        return m_w[i];
    endfunction

    function automatic int model_sum(input logic [N_IN-1:0] h, input int b);
        int s;
        s = b;
        for (int i = 0; i < N_IN; i++) begin
            if (h[i]) s += eff_w(i);
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) m_w[i] <= 0;
            m_bias  <= 0;
            m_thr   <= 0;
            m_cnt   <= 0;
            m_pend  <= 0;
            m_y     <= 1'b0;
            m_score <= 0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (m_cnt == 0) begin
                if (bus.start) begin
                    m_pend <= model_sum(bus.hidden, m_bias);
                    m_cnt  <= 1;
                end
                if (bus.wr_en) begin
                    if (bus.wr_addr < 3'd4)       m_w[bus.wr_addr] <= int'(bus.wr_data);
                    else if (bus.wr_addr == 3'd4) m_bias <= int'(bus.wr_data);
                    else if (bus.wr_addr == 3'd5) m_thr  <= int'(bus.wr_data);
                end
            end else if (m_cnt == 5) begin
                m_y     <= (m_pend > m_thr);
                m_score <= clamp8(m_pend);
                m_valid <= 1'b1;
                m_cnt   <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("valid", int'(bus.valid), int'(m_valid));
        check("busy",  int'(bus.busy),  int'(m_cnt != 0));
        check("y",     int'(bus.y),     int'(m_y));
        check("score", int'(bus.score), m_score);
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_reg(input logic [2:0] addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = w_t'(data);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic program_all(input int w0, input int w1, input int w2,
                               input int w3, input int b, input int t);
        write_reg(ADDR_W0, w0);
        write_reg(ADDR_W1, w1);
        write_reg(ADDR_W2, w2);
        write_reg(ADDR_W3, w3);
        write_reg(ADDR_BIAS, b);
        write_reg(ADDR_THR, t);
    endtask

    // Waits (bounded) for valid; lat counts edges after the start edge.
    task automatic wait_valid(input int lat0);
        int lat;
        lat = lat0;
        while (!bus.valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 5);
    endtask

    task automatic run_eval(input logic [N_IN-1:0] h, input logic flip);
        bus.hidden = h;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        if (flip) bus.hidden = ~h;
        wait_valid(0);
    endtask

    task automatic expect_result(input string name, input int sc, input logic yy);
        check({name, "_score"}, int'(bus.score), sc);
        check({name, "_y"},     int'(bus.y),     int'(yy));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        bus.hidden  = '0;
        bus.start   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  int'(bus.busy),  0);
        check("rst_valid", int'(bus.valid), 0);
        expect_result("rst", 0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic evaluations: 10+30-3, -20+5-3, bias only.
        program_all(10, -20, 30, 5, -3, 20);
        run_eval(4'b0101, 1'b0);
        expect_result("h0101", 37, 1'b1);
        check("model_h0101", m_score, 37);
        run_eval(4'b1010, 1'b0);
        expect_result("h1010", -18, 1'b0);
        run_eval(4'b0000, 1'b0);
        expect_result("h0000", -3, 1'b0);

        // start re-pulse and a write while busy are both dropped.
        bus.hidden = 4'b0101;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_W0;
        bus.wr_data = w_t'(99);
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        wait_valid(2);
        expect_result("busy_run", 37, 1'b1);
        repeat (8) @(negedge clk);
        run_eval(4'b0001, 1'b0);
        expect_result("old_w0", 7, 1'b0);

        // Write coincident with start: new weight used, old bias used.
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_W0;
        bus.wr_data = w_t'(40);
        run_eval(4'b0001, 1'b0);
        bus.wr_en   = 1'b0;
        expect_result("same_edge_w", 37, 1'b1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_BIAS;
        bus.wr_data = w_t'(50);
        bus.hidden  = 4'b0000;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        wait_valid(0);
        expect_result("same_edge_b", -3, 1'b0);
        run_eval(4'b0000, 1'b0);
        expect_result("new_bias", 50, 1'b1);

        // hidden changes right after the start edge: latched value counts.
        run_eval(4'b0100, 1'b1);
        expect_result("latched_h", 80, 1'b1);

        // Saturation at both ends.
        program_all(127, 127, 127, 127, 127, 20);
        run_eval(4'b1111, 1'b0);
        expect_result("sat_hi", 127, 1'b1);
        check("model_sat_hi", m_score, 127);
        program_all(-128, -128, -128, -128, -128, 0);
        run_eval(4'b1111, 1'b0);
        expect_result("sat_lo", -128, 1'b0);

        // Addresses 6 and 7 change nothing.
        write_reg(3'd6, 5);
        write_reg(3'd7, 5);
        run_eval(4'b0000, 1'b0);
        expect_result("addr67", -128, 1'b0);

        // Reset in the middle of an evaluation.
        bus.hidden = 4'b1111;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", int'(bus.busy), 0);
        expect_result("midrst", 0, 1'b0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_eval(4'b1111, 1'b0);
        expect_result("cleared_regs", 0, 1'b0);
        write_reg(ADDR_W0, 5);
        run_eval(4'b0001, 1'b0);
        expect_result("post_rst", 5, 1'b1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_layer_seq.md
# output_layer_seq

Sequential output neuron for the mihailocode neural network, sitting directly downstream of the first-layer perceptron/activation array. It consumes the 4 binary hidden activations and computes a signed weighted sum plus bias with a single adder over 4 cycles. It then thresholds the sum and returns a registered decision bit, a saturated 8-bit score and a one-cycle valid pulse. Weights, bias and threshold are run-time programmable through a simple register-write port.

## Interface
- N_IN, 4, number of hidden inputs (fixed at 4 in this revision)
- W_WIDTH, 8, signed weight/bias/threshold width
- ACC_WIDTH, 11, signed accumulator width (holds -640..635)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- hidden  in  4  activation bits from first layer (bit i = neuron i)
- start  in  1  request evaluation; sampled only in IDLE
- wr_en  in  1  register write strobe
- wr_addr  in  3  0..3 = weight[0..3], 4 = bias, 5 = threshold, 6..7 ignored
- wr_data  in  8  signed write value
- y  out  1  decision: acc > threshold (signed)
- score  out  8  signed acc saturated to [-128, 127]
- valid  out  1  one-cycle pulse when y/score update
- busy  out  1  high while an evaluation is in progress

## Operation
- Reset (async, rst_n=0): weights, bias and threshold = 0, state = IDLE, y = 0, score = 0, valid = 0, busy = 0, idx = 0, acc = 0.
- FSM states IDLE, ACCUM, DONE; busy = (state != IDLE).
- IDLE: if start=1 at edge, latch hidden into h_q, acc <= sign-extended bias, idx <= 0, go to ACCUM. start=0: stay.
- ACCUM: each edge acc <= acc + (h_q[idx] ? sext(weight[idx]) : 0), idx++. At idx==3, go to DONE.
- DONE: y <= (acc > sext(threshold)), score <= sat8(acc), valid <= 1, go to IDLE.
- valid is otherwise 0; y and score hold until the next DONE.
- Arithmetic: all signed two's complement, sign-extended to ACC_WIDTH. No overflow is possible at 11 bits. Saturation happens only at score.
- Writes: when wr_en=1 and state==IDLE, the register at wr_addr <= wr_data at the edge. Writes while busy are dropped silently. Addresses 6..7 are no-ops.
- Simultaneous wr_en and start in IDLE: the write takes effect, but evaluation uses the pre-write values for bias. For weights, the new value is visible from the next edge, so the new weight is used.
- start while busy: ignored, not queued. hidden changes after the start edge do not affect the result.
- Reset mid-operation: immediate return to IDLE. No valid pulse. Registers return to reset values.

## Timing
- Edge k: start sampled in IDLE; busy high after edge k.
- Edges k+1..k+4: accumulate h_q[0..3].
- Edge k+5: y/score update, valid high for the following cycle, busy low.
- Latency: start edge to valid = 5 cycles. Earliest next start is sampled at edge k+6, so throughput is 1 result per 6 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package nn_pkg: W_WIDTH, ACC_WIDTH, N_IN, address constants (ADDR_W0..ADDR_W3, ADDR_BIAS, ADDR_THR), FSM state enum, and the sat8 function.
- Sub-module weight_regfile: 4 weights, bias and threshold. It has the write port gated by an external enable, with parallel read outputs.
- Top output_layer_seq: FSM, idx counter, accumulator and output registers.

## Test plan
- Reset then program w = {10, -20, 30, 5}, bias = -3, thr = 20; hidden = 4'b0101, start -> valid exactly 5 cycles after the start edge, score = 37, y = 1, busy high for 5 cycles.
- Same weights, hidden = 4'b1010 -> acc = -18, score = -18, y = 0; hidden = 4'b0000 -> score = -3, y = 0.
- All weights = 127, bias = 127, hidden = 4'b1111 -> acc = 635, score = 127 (saturated), y = 1. All weights = -128, bias = -128, thr = 0 -> score = -128, y = 0.
- start re-pulsed and wr_en (addr 0, data 99) issued during busy -> no second evaluation, weight[0] unchanged; an evaluation on the next IDLE uses the old weight.
- Change hidden 1 cycle after start -> result reflects the latched value. Assert rst_n=0 at cycle k+3 -> no valid pulse, y = 0, score = 0, all registers cleared, and the next start works normally.
